// File: rtl/b14_pkg.sv
// Shared types for the b14 memory bridge: core bus widths and the posted-write record.
package b14_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 31;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } b14_wr_t;

endpackage

// File: rtl/b14_wfifo.sv
// Synchronous posted-write FIFO; a push into a full FIFO is accepted only when a pop frees a slot.
module b14_wfifo
    import b14_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  b14_wr_t                  din,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output b14_wr_t                  head
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    b14_wr_t         store [DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = store[rptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    // Entry storage carries no reset; pointers alone define what is valid.
    always_ff @(posedge clock) begin
        if (do_push) store[wptr] <= din;
    end

endmodule

// File: rtl/b14_mem_bridge.sv
// Memory-side bridge for the b14 core: local word RAM with registered reads, write-through
// posting of deduplicated write events to a FIFO that drains over a valid/ready port.
module b14_mem_bridge
    import b14_pkg::*;
#(
    parameter int AW         = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [DATA_W-1:0]           datao,
    input  logic                        rd,
    input  logic                        wr,
    output logic [DATA_W-1:0]           datai,
    input  logic                        pl_we,
    input  logic [AW-1:0]               pl_addr,
    input  logic [DATA_W-1:0]           pl_data,
    output logic                        ext_valid,
    output logic [ADDR_W-1:0]           ext_addr,
    output logic [DATA_W-1:0]           ext_data,
    input  logic                        ext_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        ovf,
    output logic [CNT_W-1:0]            drop_cnt
);

    logic [DATA_W-1:0] mem [2**AW];

    logic              wr_q;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] last_data;
    logic [AW-1:0]     idx;
    logic              we;
    logic              pl_hit;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              drop;
    b14_wr_t           head;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // A held strobe posts once; a changed address or data under the same strobe is a new event.
    assign idx    = addr[AW-1:0];
    assign we     = !reset && wr && (!wr_q || (addr != last_addr) || (datao != last_data));
    assign pl_hit = pl_we && (pl_addr == idx);

    assign ext_valid = !fifo_empty;
    assign pop       = ext_valid && ext_ready;
    assign drop      = we && fifo_full && !pop;
    assign ext_addr  = ext_valid ? head.a : '0;
    assign ext_data  = ext_valid ? head.d : '0;

    b14_wfifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_wfifo (
        .clock (clock),
        .reset (reset),
        .push  (we),
        .din   ('{a: addr, d: datao}),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level),
        .head  (head)
    );

    // Preload owns the index when both target it in the same cycle.
    always_ff @(posedge clock) begin
        if (we && !pl_hit) mem[idx] <= datao;
        if (pl_we)         mem[pl_addr] <= pl_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q      <= 1'b0;
            last_addr <= '0;
            last_data <= '0;
            datai     <= '0;
            ovf       <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            wr_q <= wr;
            if (we) begin
                last_addr <= addr;
                last_data <= datao;
            end
            if (rd) begin
                if (pl_hit)  datai <= pl_data;
                else if (we) datai <= datao;
                else         datai <= mem[idx];
            end
            if (drop) begin
                ovf      <= 1'b1;
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

endmodule

// File: tb/tb_b14_mem_bridge.sv
// Self-checking bench for b14_mem_bridge: directed scenarios plus randomized traffic vs a queue model.
module tb_b14_mem_bridge;

    localparam int AW    = 10;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic [19:0]   addr;
    logic [30:0]   datao;
    logic          rd, wr;
    logic [30:0]   datai;
    logic          pl_we;
    logic [AW-1:0] pl_addr;
    logic [30:0]   pl_data;
    logic          ext_valid;
    logic [19:0]   ext_addr;
    logic [30:0]   ext_data;
    logic          ext_ready;
    logic [LW-1:0] fifo_level;
    logic          ovf;
    logic [CNT_W-1:0] drop_cnt;

    int total  = 0;
    int passed = 0;

    // Reference model state
    logic [30:0] m_mem [1 << AW];
    logic [19:0] m_qa [$];
    logic [30:0] m_qd [$];
    logic [30:0] m_datai;
    bit          m_ovf;
    int          m_cnt;
    bit          m_wr_q;
    logic [19:0] m_la;
    logic [30:0] m_ld;

    always #5 clock = ~clock;

    b14_mem_bridge #(.AW(AW), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .addr(addr), .datao(datao), .rd(rd), .wr(wr),
        .datai(datai), .pl_we(pl_we), .pl_addr(pl_addr), .pl_data(pl_data),
        .ext_valid(ext_valid), .ext_addr(ext_addr), .ext_data(ext_data), .ext_ready(ext_ready),
        .fifo_level(fifo_level), .ovf(ovf), .drop_cnt(drop_cnt)
    );

    task automatic tick();
        bit we, pop;
        int sz;
        logic [AW-1:0] idx;
        @(posedge clock);
        if (reset) begin
            m_datai = '0; m_qa.delete(); m_qd.delete();
            m_ovf = 0; m_cnt = 0; m_wr_q = 0; m_la = '0; m_ld = '0;
            if (pl_we) m_mem[pl_addr] = pl_data;
        end else begin
            we  = wr && (!m_wr_q || addr != m_la || datao != m_ld);
            idx = addr[AW-1:0];
            sz  = m_qa.size();
            pop = (sz != 0) && ext_ready;
            if (rd) m_datai = (pl_we && pl_addr == idx) ? pl_data : (we ? datao : m_mem[idx]);
            if (pop) begin void'(m_qa.pop_front()); void'(m_qd.pop_front()); end
            if (we) begin
                if (sz < DEPTH || pop) begin m_qa.push_back(addr); m_qd.push_back(datao); end
                else begin m_ovf = 1; if (m_cnt < CMAX) m_cnt++; end
                m_mem[idx] = datao; m_la = addr; m_ld = datao;
            end
            if (pl_we) m_mem[pl_addr] = pl_data;
            m_wr_q = wr;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1; addr = '0; datao = '0; rd = 0; wr = 0;
        pl_we = 0; pl_addr = '0; pl_data = '0; ext_ready = 0;
        tick(); tick();
        total++; if (datai !== 31'd0) $display("FAIL reset_datai got=%h exp=0", datai); else passed++;
        total++; if (ext_valid !== 1'b0) $display("FAIL reset_ext_valid got=%b exp=0", ext_valid); else passed++;
        total++; if (ext_addr !== 20'd0) $display("FAIL reset_ext_addr got=%h exp=0", ext_addr); else passed++;
        total++; if (ext_data !== 31'd0) $display("FAIL reset_ext_data got=%h exp=0", ext_data); else passed++;
        total++; if (fifo_level !== LW'(0)) $display("FAIL reset_level got=%0d exp=0", fifo_level); else passed++;
        total++; if (ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", ovf); else passed++;
        total++; if (drop_cnt !== CNT_W'(0)) $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); else passed++;
        reset = 0;
        for (int i = 0; i < (1 << AW); i++) begin
            pl_we = 1; pl_addr = AW'(i); pl_data = 31'($urandom);
            tick();
        end
        pl_we = 0;
    endtask

    task automatic test_preload_read();
        pl_we = 1; pl_addr = AW'(5); pl_data = 31'h1234; tick();
        pl_we = 0; rd = 1; addr = 20'd5; tick();
        total++; if (datai !== 31'h1234) $display("FAIL preload_read got=%h exp=1234", datai); else passed++;
        rd = 0; addr = 20'd6; tick(); tick();
        total++; if (datai !== 31'h1234) $display("FAIL read_hold got=%h exp=1234", datai); else passed++;
    endtask

    task automatic test_held_write();
        ext_ready = 0; wr = 1; addr = 20'h00003; datao = 31'h7;
        repeat (6) tick();
        wr = 0; tick();
        total++; if (fifo_level !== LW'(1)) $display("FAIL held_level got=%0d exp=1", fifo_level); else passed++;
        total++; if (ext_valid !== 1'b1) $display("FAIL held_valid got=%b exp=1", ext_valid); else passed++;
        total++; if (ext_addr !== 20'h3 || ext_data !== 31'h7)
            $display("FAIL held_entry got=%h/%h exp=3/7", ext_addr, ext_data); else passed++;
        rd = 1; tick(); rd = 0;
        total++; if (datai !== 31'h7) $display("FAIL held_mem got=%h exp=7", datai); else passed++;
        ext_ready = 1; tick(); ext_ready = 0;
        total++; if (fifo_level !== LW'(0)) $display("FAIL held_drain got=%0d exp=0", fifo_level); else passed++;
    endtask

    task automatic test_forward();
        addr = 20'd9; datao = 31'h55; wr = 1; rd = 1; tick();
        wr = 0; rd = 0;
        total++; if (datai !== 31'h55) $display("FAIL fwd_write got=%h exp=55", datai); else passed++;
        addr = 20'd10; datao = 31'h66; wr = 1; rd = 1;
        pl_we = 1; pl_addr = AW'(10); pl_data = 31'h77; tick();
        wr = 0; rd = 0; pl_we = 0;
        total++; if (datai !== 31'h77) $display("FAIL fwd_preload got=%h exp=77", datai); else passed++;
        rd = 1; tick(); rd = 0;
        total++; if (datai !== 31'h77) $display("FAIL preload_wins_mem got=%h exp=77", datai); else passed++;
        total++; if (fifo_level !== LW'(2)) $display("FAIL fwd_level got=%0d exp=2", fifo_level); else passed++;
        ext_ready = 1; tick(); tick(); ext_ready = 0;
    endtask

    task automatic test_overflow_drain();
        ext_ready = 0; wr = 1;
        for (int i = 0; i < 5; i++) begin
            addr = 20'h100 + 20'(i); datao = 31'hA0 + 31'(i); tick();
        end
        wr = 0; tick();
        total++; if (fifo_level !== LW'(4)) $display("FAIL ovf_level got=%0d exp=4", fifo_level); else passed++;
        total++; if (ovf !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", ovf); else passed++;
        total++; if (drop_cnt !== CNT_W'(1)) $display("FAIL ovf_drop got=%0d exp=1", drop_cnt); else passed++;
        ext_ready = 1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (ext_valid !== 1'b1 || ext_addr !== 20'h100 + 20'(k) || ext_data !== 31'hA0 + 31'(k))
                $display("FAIL drain_order%0d got=%b/%h/%h exp=1/%h/%h", k, ext_valid, ext_addr, ext_data,
                         20'h100 + 20'(k), 31'hA0 + 31'(k));
            else passed++;
            tick();
        end
        total++; if (ext_valid !== 1'b0) $display("FAIL drain_done got=%b exp=0", ext_valid); else passed++;
        ext_ready = 0;
    endtask

    task automatic test_full_push_pop();
        logic [19:0] ea [4];
        logic [30:0] ed [4];
        ea = '{20'h201, 20'h202, 20'h203, 20'h2FF};
        ed = '{31'hB1, 31'hB2, 31'hB3, 31'hCC};
        ext_ready = 0; wr = 1;
        for (int i = 0; i < 4; i++) begin
            addr = 20'h200 + 20'(i); datao = 31'hB0 + 31'(i); tick();
        end
        addr = 20'h2FF; datao = 31'hCC; ext_ready = 1; tick();
        wr = 0; ext_ready = 0;
        total++; if (fifo_level !== LW'(4)) $display("FAIL fullpp_level got=%0d exp=4", fifo_level); else passed++;
        total++; if (drop_cnt !== CNT_W'(1)) $display("FAIL fullpp_drop got=%0d exp=1", drop_cnt); else passed++;
        ext_ready = 1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (ext_addr !== ea[k] || ext_data !== ed[k])
                $display("FAIL fullpp_order%0d got=%h/%h exp=%h/%h", k, ext_addr, ext_data, ea[k], ed[k]);
            else passed++;
            tick();
        end
        ext_ready = 0;
    endtask

    task automatic test_reset_mid();
        ext_ready = 0; wr = 1;
        for (int i = 0; i < 3; i++) begin
            addr = 20'h300 + 20'(i); datao = 31'hC0 + 31'(i); tick();
        end
        wr = 0; rd = 1; addr = 20'h301; tick(); rd = 0;
        total++; if (fifo_level !== LW'(3) || ovf !== 1'b1)
            $display("FAIL pre_reset got=%0d/%b exp=3/1", fifo_level, ovf); else passed++;
        reset = 1; tick(); reset = 0;
        total++; if (ext_valid !== 1'b0) $display("FAIL rst_mid_valid got=%b exp=0", ext_valid); else passed++;
        total++; if (fifo_level !== LW'(0)) $display("FAIL rst_mid_level got=%0d exp=0", fifo_level); else passed++;
        total++; if (ovf !== 1'b0 || drop_cnt !== CNT_W'(0))
            $display("FAIL rst_mid_ovf got=%b/%0d exp=0/0", ovf, drop_cnt); else passed++;
        total++; if (datai !== 31'd0) $display("FAIL rst_mid_datai got=%h exp=0", datai); else passed++;
        rd = 1; addr = 20'h302; tick(); rd = 0;
        total++; if (datai !== 31'hC2) $display("FAIL rst_mem_kept got=%h exp=c2", datai); else passed++;
    endtask

    task automatic test_saturate();
        ext_ready = 0; wr = 1; addr = 20'h400;
        for (int i = 0; i < 300; i++) begin
            datao = 31'(i); tick();
        end
        wr = 0; tick();
        total++; if (drop_cnt !== CNT_W'(CMAX)) $display("FAIL sat_drop got=%0d exp=%0d", drop_cnt, CMAX); else passed++;
        total++; if (ovf !== 1'b1 || fifo_level !== LW'(4))
            $display("FAIL sat_state got=%b/%0d exp=1/4", ovf, fifo_level); else passed++;
        ext_ready = 1; repeat (4) tick(); ext_ready = 0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            wr        = ($urandom_range(0, 9) < 6);
            rd        = $urandom_range(0, 1);
            ext_ready = ($urandom_range(0, 9) < 4);
            addr      = {10'($urandom_range(0, 1)), 10'($urandom_range(0, 15))};
            datao     = 31'($urandom_range(0, 3));
            pl_we     = ($urandom_range(0, 9) == 0);
            pl_addr   = AW'($urandom_range(0, 15));
            pl_data   = 31'($urandom);
            tick();
            total++; if (datai !== m_datai) $display("FAIL rnd_datai n=%0d got=%h exp=%h", n, datai, m_datai); else passed++;
            total++; if (fifo_level !== LW'(m_qa.size()))
                $display("FAIL rnd_level n=%0d got=%0d exp=%0d", n, fifo_level, m_qa.size()); else passed++;
            total++; if (ext_valid !== (m_qa.size() != 0))
                $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, ext_valid, m_qa.size() != 0); else passed++;
            total++; if (ovf !== m_ovf || drop_cnt !== CNT_W'(m_cnt))
                $display("FAIL rnd_ovf n=%0d got=%b/%0d exp=%b/%0d", n, ovf, drop_cnt, m_ovf, m_cnt); else passed++;
            if (m_qa.size() != 0) begin
                total++;
                if (ext_addr !== m_qa[0] || ext_data !== m_qd[0])
                    $display("FAIL rnd_head n=%0d got=%h/%h exp=%h/%h", n, ext_addr, ext_data, m_qa[0], m_qd[0]);
                else passed++;
            end
        end
        wr = 0; rd = 0; pl_we = 0; ext_ready = 0;
    endtask

    initial begin
        test_reset();
        test_preload_read();
        test_held_write();
        test_forward();
        test_overflow_drain();
        test_full_push_pop();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
